prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 119 +++++++++++
 tb/tb_prog_timer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - programmable one-shot/periodic timer with terminal-count tick and sticky done.
// Optional o_Half output enabled by defining PROG_TIMER_HALF_EN.
module prog_timer #(
  parameter int          WIDTH    = 12,
  parameter int unsigned TERM_RST = 2**WIDTH - 1
) (
  input  logic             clk_2K,
  input  logic             i_Reset,
  input  logic             i_Clear,
  input  logic             i_Enable,
  input  logic             i_Mode,
  input  logic             i_Load,
  input  logic [WIDTH-1:0] i_LoadValue,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Tick,
  output logic             o_Done,
  output logic             o_Running
`ifdef PROG_TIMER_HALF_EN
  ,
  output logic             o_Half
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TERM_INIT = TERM_RST[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] term_q;
  logic             tick_q;
  logic             done_q;
  logic             mode_q;

  logic [WIDTH-1:0] load_term_d;
  logic             at_term_d;

  // A zero terminal count would never be reached, so it is stored as 1.
  assign load_term_d = (i_LoadValue == '0) ? ONE : i_LoadValue;
  assign at_term_d   = (count_q == (term_q - ONE));

  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= TERM_INIT;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (i_Clear) begin
        // Clear forces IDLE, so a simultaneous load is always accepted.
        state_q <= S_IDLE;
        count_q <= '0;
        done_q  <= 1'b0;
        if (i_Load) term_q <= load_term_d;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_Load) term_q <= load_term_d;
            if (i_Enable) begin
              mode_q <= i_Mode;
              if (term_q == ONE) begin
                tick_q <= 1'b1;
                done_q <= 1'b1;
                if (i_Mode) begin
                  count_q <= '0;
                  state_q <= S_RUN;
                end else begin
                  count_q <= ONE;
                  state_q <= S_DONE;
                end
              end else begin
                count_q <= ONE;
                state_q <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (i_Enable) begin
              if (at_term_d) begin
                tick_q <= 1'b1;
                done_q <= 1'b1;
                if (mode_q) begin
                  count_q <= '0;
                end else begin
                  count_q <= term_q;
                  state_q <= S_DONE;
                end
              end else begin
                count_q <= count_q + ONE;
              end
            end
          end
          S_DONE: begin
            if (i_Load) term_q <= load_term_d;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o_Count   = count_q;
  assign o_Tick    = tick_q;
  assign o_Done    = done_q;
  assign o_Running = (state_q == S_RUN);

`ifdef PROG_TIMER_HALF_EN
  assign o_Half = (state_q != S_IDLE) && (count_q >= (term_q >> 1));
`endif

endmodule

// File: tb/tb_prog_timer.sv
// tb/tb_prog_timer.sv - self-checking bench for prog_timer: vector table, directed corners, randomized model compare.
module tb_prog_timer;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0, en = 1'b0, md = 1'b0, ld = 1'b0;
  logic [W-1:0] lv = '0;
  logic [W-1:0] count;
  logic         tick, done, running;
`ifdef PROG_TIMER_HALF_EN
  logic         half;
`endif

  int checks = 0;
  int errors = 0;

  int m_phase, m_cnt, m_term, m_mode, m_tick, m_done;

  prog_timer #(.WIDTH(W)) dut (
    .clk_2K      (clk),
    .i_Reset     (rst_n),
    .i_Clear     (clr),
    .i_Enable    (en),
    .i_Mode      (md),
    .i_Load      (ld),
    .i_LoadValue (lv),
    .o_Count     (count),
    .o_Tick      (tick),
    .o_Done      (done),
    .o_Running   (running)
`ifdef PROG_TIMER_HALF_EN
    ,
    .o_Half      (half)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         c, e, m, l;
    logic [W-1:0] v;
    logic [W-1:0] cnt;
    logic         t, d, r;
  } vec_t;

  function automatic vec_t mk(int c, int e, int m, int l, int v, int cnt, int t, int d, int r);
    vec_t x;
    x.c = c[0]; x.e = e[0]; x.m = m[0]; x.l = l[0];
    x.v = v[W-1:0]; x.cnt = cnt[W-1:0];
    x.t = t[0]; x.d = d[0]; x.r = r[0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_term = 4095; m_mode = 0; m_tick = 0; m_done = 0;
  endtask

  // Phase 0 idle, 1 running, 2 finished; an enabled edge advances the count by one
  // and the tick fires when the advanced count equals the terminal count.
  task automatic model_step();
    int n, old_term;
    old_term = m_term;
    m_tick = 0;
    if (clr) begin
      if (ld) m_term = (lv == 0) ? 1 : int'(lv);
      m_cnt = 0; m_done = 0; m_phase = 0;
    end else begin
      if (ld && m_phase != 1) m_term = (lv == 0) ? 1 : int'(lv);
      if (en && m_phase != 2) begin
        if (m_phase == 0) m_mode = int'(md);
        n = ((m_phase == 0) ? 0 : m_cnt) + 1;
        if (n == old_term) begin
          m_tick = 1; m_done = 1;
          if (m_mode == 1) begin m_cnt = 0; m_phase = 1; end
          else begin m_cnt = n; m_phase = 2; end
        end else begin
          m_cnt = n; m_phase = 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, count, m_cnt);
    chk({tag, ".tick"}, tick, m_tick);
    chk({tag, ".done"}, done, m_done);
    chk({tag, ".running"}, running, (m_phase == 1) ? 1 : 0);
`ifdef PROG_TIMER_HALF_EN
    chk({tag, ".half"}, half, (m_phase != 0 && m_cnt >= m_term / 2) ? 1 : 0);
`endif
  endtask

  task automatic do_reset();
    clr = 0; en = 0; md = 0; ld = 0; lv = '0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    int   ticks, changed;
    int   tq[$];

    tbl[0]  = mk(0,0,0,1,3, 0,0,0,0);
    tbl[1]  = mk(0,1,0,0,0, 1,0,0,1);
    tbl[2]  = mk(0,1,0,0,0, 2,0,0,1);
    tbl[3]  = mk(0,1,0,0,0, 3,1,1,0);
    tbl[4]  = mk(0,1,0,0,0, 3,0,1,0);
    tbl[5]  = mk(0,0,0,1,0, 3,0,1,0);
    tbl[6]  = mk(1,0,0,1,2, 0,0,0,0);
    tbl[7]  = mk(0,1,1,0,0, 1,0,0,1);
    tbl[8]  = mk(0,1,1,0,0, 0,1,1,1);
    tbl[9]  = mk(0,1,1,0,0, 1,0,1,1);
    tbl[10] = mk(0,0,1,1,7, 1,0,1,1);
    tbl[11] = mk(0,1,1,0,0, 0,1,1,1);
    tbl[12] = mk(1,1,1,0,0, 0,0,0,0);
    tbl[13] = mk(0,0,0,1,0, 0,0,0,0);
    tbl[14] = mk(0,1,1,0,0, 0,1,1,1);
    tbl[15] = mk(0,1,1,0,0, 0,1,1,1);
    tbl[16] = mk(0,0,1,0,0, 0,0,1,1);
    tbl[17] = mk(0,1,0,0,0, 0,1,1,1);
    tbl[18] = mk(1,0,0,0,0, 0,0,0,0);
    tbl[19] = mk(0,1,0,0,0, 1,1,1,0);
    tbl[20] = mk(0,1,0,0,0, 1,0,1,0);
    tbl[21] = mk(1,0,0,0,0, 0,0,0,0);

    #1;
    chk("reset.count", count, 0);
    chk("reset.tick", tick, 0);
    chk("reset.done", done, 0);
    chk("reset.running", running, 0);
    do_reset();

    for (int i = 0; i < 22; i++) begin
      clr = tbl[i].c; en = tbl[i].e; md = tbl[i].m; ld = tbl[i].l; lv = tbl[i].v;
      step();
      chk($sformatf("vec%0d.count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d.tick", i), tick, tbl[i].t);
      chk($sformatf("vec%0d.done", i), done, tbl[i].d);
      chk($sformatf("vec%0d.running", i), running, tbl[i].r);
    end
    clr = 0; en = 0; ld = 0;

    // Async reset mid-count, then a full one-shot run with the restored terminal count.
    do_reset();
    en = 1; md = 0;
    repeat (1000) step();
    chk("midcount.count", count, 1000);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst.count", count, 0);
    chk("async_rst.running", running, 0);
    chk("async_rst.done", done, 0);
    chk("async_rst.tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 4095; i++) begin
      step();
      if (i < 4095 && tick) ticks++;
    end
    chk("full.early_ticks", ticks, 0);
    chk("full.tick", tick, 1);
    chk("full.count", count, 4095);
    chk("full.done", done, 1);
    chk("full.running", running, 0);
    changed = 0;
    repeat (100) begin
      step();
      if (count != 4095 || tick || !done || running) changed++;
    end
    chk("full.hold_changes", changed, 0);

    // Periodic with terminal 10 over 35 enabled edges.
    en = 0; clr = 1; step(); clr = 0;
    ld = 1; lv = 10; step(); ld = 0;
    en = 1; md = 1;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (tick) tq.push_back(i);
    end
    chk("periodic.nticks", tq.size(), 3);
    if (tq.size() == 3) begin
      chk("periodic.tick0", tq[0], 10);
      chk("periodic.tick1", tq[1], 20);
      chk("periodic.tick2", tq[2], 30);
    end
    chk("periodic.count", count, 5);
    chk("periodic.done", done, 1);

    // Pause in the middle of a one-shot run.
    en = 0; clr = 1; step(); clr = 0;
    ld = 1; lv = 20; md = 0; step(); ld = 0;
    en = 1; repeat (7) step();
    chk("pause.pre", count, 7);
    en = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("pause.hold%0d", i), count, 7);
    end
    en = 1;
    for (int i = 1; i <= 13; i++) begin
      step();
      chk($sformatf("pause.tick%0d", i), tick, (i == 13) ? 1 : 0);
    end
    chk("pause.count", count, 20);

    // Load during RUN is ignored; clear returns to IDLE.
    en = 0; clr = 1; step(); clr = 0;
    ld = 1; lv = 4095; step(); ld = 0;
    en = 1; repeat (300) step();
    chk("runload.pre", count, 300);
    en = 0; ld = 1; lv = 50; step(); ld = 0;
    chk("runload.count", count, 300);
    chk("runload.running", running, 1);
    en = 1; ticks = 0;
    repeat (60) begin step(); if (tick) ticks++; end
    chk("runload.no_tick", ticks, 0);
    en = 0; clr = 1; step(); clr = 0;
    chk("clear.count", count, 0);
    chk("clear.running", running, 0);
    chk("clear.done", done, 0);

`ifdef PROG_TIMER_HALF_EN
    ld = 1; lv = 9; step(); ld = 0;
    en = 1; md = 0;
    repeat (3) step();
    chk("half.at3", half, 0);
    step();
    chk("half.at4", half, 1);
    en = 0; clr = 1; step(); clr = 0;
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom % 40) == 0;
      en  = ($urandom % 4) != 0;
      md  = $urandom % 2;
      ld  = ($urandom % 8) == 0;
      lv  = W'($urandom_range(0, 12));
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
